wb_stage: RTL and testbench
===========================

# wb_stage

Parametrised, registered writeback stage for the MIPS64 core. It sits between MEM/WB and the register-file write port. It selects among memory data, ALU result and PC+4, and aligns and extends sub-doubleword loads. It also merges results from long-latency units (mult/div) through a small queue onto the single write port, back-pressuring the pipeline when that queue fills.

## Interface
Parameters:
- WIDTH, 64, datapath width in bits
- ADDR, 5, register-address width
- LQ_DEPTH, 4, long-result queue depth (power of two, ≥2)

Ports:
- p_Clk  in  1  clock; all state on rising edge
- p_Reset_n  in  1  asynchronous, active-low reset
- p_WB_Valid  in  1  pipeline writeback slot valid
- p_WB_MemData  in  WIDTH  raw load data (doubleword, as read)
- p_WB_ALUResult  in  WIDTH  ALU result
- p_WB_PC_4  in  WIDTH  link address
- p_WB_RegDestIN  in  ADDR  destination register
- p_WB_Ctrl_Bus  in  5  {StoreOp, LoadOp, JumpSel, RegWrite, MemToReg}
- p_WB_LdSize  in  2  00 byte, 01 half, 10 word, 11 dword
- p_WB_LdUnsigned  in  1  1 = zero-extend, 0 = sign-extend
- p_WB_LdAddrLo  in  3  load address bits [2:0] (byte lane)
- p_LR_Valid  in  1  long-unit result valid
- p_LR_Ready  out  1  queue can accept
- p_LR_Data  in  WIDTH  long-unit result
- p_LR_Dest  in  ADDR  long-unit destination
- p_WB_Stall  out  1  freeze upstream pipeline
- p_RF_WE  out  1  register-file write enable
- p_RF_Addr  out  ADDR  register-file write address
- p_RF_Data  out  WIDTH  register-file write data
- p_LR_Pending  out  clog2(LQ_DEPTH)+1  queue occupancy

## Operation
- Pipeline data mux: MemToReg=1 → ALU result, 0 → load data; JumpSel=1 overrides with PC+4.
- Load data: select lane by p_WB_LdAddrLo, i.e. bits [8*a +: 8·size], with a=LdAddrLo aligned down to the access size; extend per LdUnsigned. Dword passes through.
- Pipeline request = p_WB_Valid & RegWrite & !p_WB_Stall.
- Long result accepted on p_LR_Valid & p_LR_Ready; p_LR_Ready = (count < LQ_DEPTH).
- Write-port arbitration each cycle: a pipeline request wins; otherwise the queue head is dequeued if non-empty.
- p_WB_Stall = (count == LQ_DEPTH). While it is high, pipeline inputs are ignored and the queue drains at one entry per cycle.
- Writes to register 0 are dropped: p_RF_WE stays 0, and a queue entry still pops.
- Same-destination ordering between queued and pipeline writes is the scoreboard's responsibility, not this block's.

## Timing
- Reset: p_RF_WE=0, p_RF_Addr=0, p_RF_Data=0, queue empty, p_LR_Pending=0, p_LR_Ready=1, p_WB_Stall=0.
- Pipeline latency: request sampled at edge N drives p_RF_* during cycle N+1.
- Long-result latency: accepted at edge N, eligible at N+1, earliest on p_RF_* at N+2.
- Simultaneous enqueue and dequeue: count unchanged; entries wrap modulo LQ_DEPTH.
- Full queue: ready drops in the cycle after the edge that fills it; stall asserts in the same cycle.
- Reset mid-operation: queued results are discarded and outputs return to reset values immediately.
- All outputs are registered except p_LR_Ready and p_WB_Stall, which decode directly from the registered count.

## Configuration
- WB_LOAD_EXT_EN defined: lane select and sign/zero extension as above.
- WB_LOAD_EXT_EN undefined: p_WB_MemData is written raw. LdSize, LdUnsigned and LdAddrLo are ignored, and sub-doubleword loads must be handled upstream.

## Structure
- Package wb_pkg: control-bus bit indices (STORE=4, LOAD=3, JUMP=2, REGW=1, MEM2REG=0) and LdSize encodings.
- Sub-module wb_lq_fifo: LQ_DEPTH×(ADDR+WIDTH) circular buffer with read/write pointers, count, full/empty flags.

## Test plan
- ALU write: Valid=1, Ctrl=00011, ALU=0x1234, dest=7 → next cycle WE=1, Addr=7, Data=0x1234.
- Signed byte load: LdSize=00, LdUnsigned=0, LdAddrLo=3, MemData=0x00000000_80FF0000 → Data=0xFFFFFFFF_FFFFFF80.
- JAL link: Ctrl=00110, PC_4=0x400 → Data=0x400; dest=0 with RegWrite → WE stays 0.
- Arbitration: long result (dest 5, 0xAA) accepted while the pipeline writes every cycle → held; it is written the first cycle after the pipeline goes idle.
- Fill queue with 4 results during continuous pipeline writes → Ready=0, Stall=1, four drain cycles, then Stall=0 and Pending=0.
- Assert reset with Pending=3 → Pending=0, WE=0 immediately; no queued write appears afterwards.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: control-bus bit positions and load-size encodings.
// Pure declarations; no logic, no latency, no backpressure.
package wb_pkg;

    localparam int unsigned CTRL_STORE   = 4;
    localparam int unsigned CTRL_LOAD    = 3;
    localparam int unsigned CTRL_JUMP    = 2;
    localparam int unsigned CTRL_REGW    = 1;
    localparam int unsigned CTRL_MEM2REG = 0;

    typedef enum logic [1:0] {
        LD_BYTE  = 2'b00,
        LD_HALF  = 2'b01,
        LD_WORD  = 2'b10,
        LD_DWORD = 2'b11
    } ld_size_e;

endpackage

// File: rtl/wb_lq_fifo.sv
// Circular buffer holding long-unit results until the register-file write port is free.
// Latency: an entry pushed at edge N is visible at the head from cycle N+1.
// Backpressure: push ignored when full, pop ignored when empty; count/full/empty are registered.
module wb_lq_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 69
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: selects mem/ALU/link data, merges long-unit results onto one RF write port.
// Latency: pipeline request -> RF one cycle; long result -> RF two cycles at earliest.
// Backpressure: p_LR_Ready low and p_WB_Stall high while the long-result queue is full. Macro: WB_LOAD_EXT_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int ADDR     = 5,
    parameter int LQ_DEPTH = 4
) (
    input  logic                        p_Clk,
    input  logic                        p_Reset_n,
    input  logic                        p_WB_Valid,
    input  logic [WIDTH-1:0]            p_WB_MemData,
    input  logic [WIDTH-1:0]            p_WB_ALUResult,
    input  logic [WIDTH-1:0]            p_WB_PC_4,
    input  logic [ADDR-1:0]             p_WB_RegDestIN,
    input  logic [4:0]                  p_WB_Ctrl_Bus,
    input  logic [1:0]                  p_WB_LdSize,
    input  logic                        p_WB_LdUnsigned,
    input  logic [2:0]                  p_WB_LdAddrLo,
    input  logic                        p_LR_Valid,
    output logic                        p_LR_Ready,
    input  logic [WIDTH-1:0]            p_LR_Data,
    input  logic [ADDR-1:0]             p_LR_Dest,
    output logic                        p_WB_Stall,
    output logic                        p_RF_WE,
    output logic [ADDR-1:0]             p_RF_Addr,
    output logic [WIDTH-1:0]            p_RF_Data,
    output logic [$clog2(LQ_DEPTH):0]   p_LR_Pending
);

    logic                 lq_full, lq_empty, lq_push, lq_pop;
    logic [ADDR+WIDTH-1:0] lq_head;
    logic                 pipe_req;
    logic [WIDTH-1:0]     ld_data, pipe_data;

    logic                 rf_we_q, rf_we_d;
    logic [ADDR-1:0]      rf_addr_q, rf_addr_d;
    logic [WIDTH-1:0]     rf_data_q, rf_data_d;

    wb_lq_fifo #(
        .DEPTH (LQ_DEPTH),
        .DW    (ADDR + WIDTH)
    ) u_lq (
        .clk   (p_Clk),
        .rst_n (p_Reset_n),
        .push  (lq_push),
        .wdata ({p_LR_Dest, p_LR_Data}),
        .pop   (lq_pop),
        .rdata (lq_head),
        .count (p_LR_Pending),
        .full  (lq_full),
        .empty (lq_empty)
    );

    assign p_LR_Ready = ~lq_full;
    assign p_WB_Stall = lq_full;
    assign lq_push    = p_LR_Valid & ~lq_full;
    assign pipe_req   = p_WB_Valid & p_WB_Ctrl_Bus[CTRL_REGW] & ~p_WB_Stall;
    assign lq_pop     = ~pipe_req & ~lq_empty;

`ifdef WB_LOAD_EXT_EN
    logic [2:0]       lane;
    logic [WIDTH-1:0] shifted;
    logic             sext;

    always_comb begin
        lane    = 3'd0;
        ld_data = p_WB_MemData;
        sext    = ~p_WB_LdUnsigned;
        // Lane index is the load address aligned down to the access size.
        case (ld_size_e'(p_WB_LdSize))
            LD_BYTE: lane = p_WB_LdAddrLo;
            LD_HALF: lane = {p_WB_LdAddrLo[2:1], 1'b0};
            LD_WORD: lane = {p_WB_LdAddrLo[2], 2'b00};
            default: lane = 3'd0;
        endcase
        shifted = p_WB_MemData >> {lane, 3'b000};
        case (ld_size_e'(p_WB_LdSize))
            LD_BYTE: ld_data = {{(WIDTH-8){sext & shifted[7]}},   shifted[7:0]};
            LD_HALF: ld_data = {{(WIDTH-16){sext & shifted[15]}}, shifted[15:0]};
            LD_WORD: ld_data = {{(WIDTH-32){sext & shifted[31]}}, shifted[31:0]};
            default: ld_data = p_WB_MemData;
        endcase
    end

    logic unused_ctrl;
    assign unused_ctrl = ^{p_WB_Ctrl_Bus[CTRL_STORE], p_WB_Ctrl_Bus[CTRL_LOAD]};
`else
    assign ld_data = p_WB_MemData;

    logic unused_ld;
    assign unused_ld = ^{p_WB_LdSize, p_WB_LdUnsigned, p_WB_LdAddrLo,
                         p_WB_Ctrl_Bus[CTRL_STORE], p_WB_Ctrl_Bus[CTRL_LOAD]};
`endif

    always_comb begin
        pipe_data = p_WB_Ctrl_Bus[CTRL_MEM2REG] ? p_WB_ALUResult : ld_data;
        if (p_WB_Ctrl_Bus[CTRL_JUMP]) pipe_data = p_WB_PC_4;
    end

    // Addr/data hold their last value when idle; only WE needs to fall.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (pipe_req) begin
            rf_we_d   = (p_WB_RegDestIN != '0);
            rf_addr_d = p_WB_RegDestIN;
            rf_data_d = pipe_data;
        end else if (lq_pop) begin
            rf_we_d   = (lq_head[ADDR+WIDTH-1:WIDTH] != '0);
            rf_addr_d = lq_head[ADDR+WIDTH-1:WIDTH];
            rf_data_d = lq_head[WIDTH-1:0];
        end
    end

    always_ff @(posedge p_Clk or negedge p_Reset_n) begin
        if (!p_Reset_n) begin
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign p_RF_WE   = rf_we_q;
    assign p_RF_Addr = rf_addr_q;
    assign p_RF_Data = rf_data_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: vector table for the pipeline mux, sequences for queue behaviour.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [63:0] mem_data = '0, alu = '0, pc4 = '0, lr_data = '0;
    logic [4:0]  dest = '0, lr_dest = '0;
    logic [4:0]  ctrl = '0;
    logic [1:0]  ld_size = '0;
    logic        ld_uns = 1'b0;
    logic [2:0]  ld_lo = '0;
    logic        lr_valid = 1'b0;
    logic        lr_ready, stall, rf_we;
    logic [4:0]  rf_addr;
    logic [63:0] rf_data;
    logic [2:0]  pending;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .p_Clk          (clk),
        .p_Reset_n      (rst_n),
        .p_WB_Valid     (wb_valid),
        .p_WB_MemData   (mem_data),
        .p_WB_ALUResult (alu),
        .p_WB_PC_4      (pc4),
        .p_WB_RegDestIN (dest),
        .p_WB_Ctrl_Bus  (ctrl),
        .p_WB_LdSize    (ld_size),
        .p_WB_LdUnsigned(ld_uns),
        .p_WB_LdAddrLo  (ld_lo),
        .p_LR_Valid     (lr_valid),
        .p_LR_Ready     (lr_ready),
        .p_LR_Data      (lr_data),
        .p_LR_Dest      (lr_dest),
        .p_WB_Stall     (stall),
        .p_RF_WE        (rf_we),
        .p_RF_Addr      (rf_addr),
        .p_RF_Data      (rf_data),
        .p_LR_Pending   (pending)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [4:0]  ctrl;
        logic [63:0] mem;
        logic [63:0] alu;
        logic [63:0] pc4;
        logic [4:0]  dest;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  lo;
        logic        exp_we;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_alu(input logic v, input logic [4:0] d, input logic [63:0] a);
        wb_valid = v;
        ctrl     = 5'b00011;
        dest     = d;
        alu      = a;
    endtask

    initial begin
        vecs[0] = '{"alu_write",   1, 5'b00011, 64'h0, 64'h1234, 64'h0, 5'd7, 2'b00, 0, 3'd0, 1, 64'h1234};
`ifdef WB_LOAD_EXT_EN
        vecs[1] = '{"lb_signed",   1, 5'b01010, 64'h0000_0000_80FF_0000, 64'h0, 64'h0, 5'd3, 2'b00, 0, 3'd3, 1, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[2] = '{"lhu_align",   1, 5'b01010, 64'h8001_2345_6789_ABCD, 64'h0, 64'h0, 5'd4, 2'b01, 1, 3'd7, 1, 64'h0000_0000_0000_8001};
        vecs[3] = '{"lw_signed",   1, 5'b01010, 64'h8001_2345_6789_ABCD, 64'h0, 64'h0, 5'd5, 2'b10, 0, 3'd5, 1, 64'hFFFF_FFFF_8001_2345};
        vecs[4] = '{"lbu_lane0",   1, 5'b01010, 64'h8001_2345_6789_ABCD, 64'h0, 64'h0, 5'd6, 2'b00, 1, 3'd0, 1, 64'h0000_0000_0000_00CD};
`else
        vecs[1] = '{"lb_raw",      1, 5'b01010, 64'h0000_0000_80FF_0000, 64'h0, 64'h0, 5'd3, 2'b00, 0, 3'd3, 1, 64'h0000_0000_80FF_0000};
        vecs[2] = '{"lhu_raw",     1, 5'b01010, 64'h8001_2345_6789_ABCD, 64'h0, 64'h0, 5'd4, 2'b01, 1, 3'd7, 1, 64'h8001_2345_6789_ABCD};
        vecs[3] = '{"lw_raw",      1, 5'b01010, 64'h1111_2222_3333_4444, 64'h0, 64'h0, 5'd5, 2'b10, 0, 3'd5, 1, 64'h1111_2222_3333_4444};
        vecs[4] = '{"lbu_raw",     1, 5'b01010, 64'h0000_0000_0000_00FF, 64'h0, 64'h0, 5'd6, 2'b00, 1, 3'd0, 1, 64'h0000_0000_0000_00FF};
`endif
        vecs[5] = '{"ld_dword",    1, 5'b01010, 64'hFEDC_BA98_7654_3210, 64'h0, 64'h0, 5'd8, 2'b11, 0, 3'd0, 1, 64'hFEDC_BA98_7654_3210};
        vecs[6] = '{"jal_link",    1, 5'b00110, 64'h55, 64'h66, 64'h400, 5'd31, 2'b00, 0, 3'd0, 1, 64'h400};
        vecs[7] = '{"jal_r0",      1, 5'b00110, 64'h55, 64'h66, 64'h800, 5'd0, 2'b00, 0, 3'd0, 0, 64'h0};
        vecs[8] = '{"not_valid",   0, 5'b00011, 64'h0, 64'h77, 64'h0, 5'd9, 2'b00, 0, 3'd0, 0, 64'h0};
        vecs[9] = '{"store_norw",  1, 5'b10000, 64'h0, 64'h88, 64'h0, 5'd9, 2'b00, 0, 3'd0, 0, 64'h0};

        #2;
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_addr", 64'(rf_addr), 64'd0);
        chk("rst_data", rf_data, 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_ready", 64'(lr_ready), 64'd1);
        chk("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            wb_valid = vecs[i].valid;
            ctrl     = vecs[i].ctrl;
            mem_data = vecs[i].mem;
            alu      = vecs[i].alu;
            pc4      = vecs[i].pc4;
            dest     = vecs[i].dest;
            ld_size  = vecs[i].size;
            ld_uns   = vecs[i].uns;
            ld_lo    = vecs[i].lo;
            step();
            chk({vecs[i].name, "_we"}, 64'(rf_we), 64'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                chk({vecs[i].name, "_addr"}, 64'(rf_addr), 64'(vecs[i].dest));
                chk({vecs[i].name, "_data"}, rf_data, vecs[i].exp_data);
            end
        end
        wb_valid = 1'b0;
        step();

        // Long result held off while the pipeline writes every cycle.
        pipe_alu(1'b1, 5'd10, 64'h1000);
        lr_valid = 1'b1; lr_dest = 5'd5; lr_data = 64'hAA;
        step();
        lr_valid = 1'b0;
        chk("arb_p0_addr", 64'(rf_addr), 64'd10);
        chk("arb_pend0", 64'(pending), 64'd1);
        for (int k = 1; k < 4; k++) begin
            alu = 64'h1000 + 64'(k);
            step();
            chk("arb_pipe_we", 64'(rf_we), 64'd1);
            chk("arb_pipe_data", rf_data, 64'h1000 + 64'(k));
            chk("arb_pend", 64'(pending), 64'd1);
        end
        wb_valid = 1'b0;
        step();
        chk("arb_lr_we", 64'(rf_we), 64'd1);
        chk("arb_lr_addr", 64'(rf_addr), 64'd5);
        chk("arb_lr_data", rf_data, 64'hAA);
        chk("arb_lr_pend", 64'(pending), 64'd0);

        // Fill the queue under continuous pipeline writes.
        pipe_alu(1'b1, 5'd20, 64'h2000);
        for (int k = 0; k < 4; k++) begin
            lr_valid = 1'b1; lr_dest = 5'(11 + k); lr_data = 64'h100 + 64'(k);
            chk("fill_ready_pre", 64'(lr_ready), 64'd1);
            step();
            chk("fill_pend", 64'(pending), 64'(k + 1));
            chk("fill_pipe_addr", 64'(rf_addr), 64'd20);
        end
        lr_valid = 1'b1; lr_dest = 5'd30; lr_data = 64'hBAD;
        chk("full_ready", 64'(lr_ready), 64'd0);
        chk("full_stall", 64'(stall), 64'd1);
        dest = 5'd21; alu = 64'hDEAD;
        step();
        lr_valid = 1'b0;
        chk("stall_ignore_addr", 64'(rf_addr), 64'd11);
        chk("stall_ignore_data", rf_data, 64'h100);
        chk("stall_drop_pend", 64'(pending), 64'd3);
        chk("stall_drop", 64'(stall), 64'd0);
        wb_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step();
            chk("drain_we", 64'(rf_we), 64'd1);
            chk("drain_addr", 64'(rf_addr), 64'(11 + k));
            chk("drain_data", rf_data, 64'h100 + 64'(k));
        end
        chk("drain_pend", 64'(pending), 64'd0);
        chk("drain_stall", 64'(stall), 64'd0);
        chk("drain_ready", 64'(lr_ready), 64'd1);
        step();
        chk("drain_idle_we", 64'(rf_we), 64'd0);

        // Queued write to r0 pops without a write.
        lr_valid = 1'b1; lr_dest = 5'd0; lr_data = 64'h77;
        step();
        lr_valid = 1'b0;
        chk("r0_pend_in", 64'(pending), 64'd1);
        step();
        chk("r0_we", 64'(rf_we), 64'd0);
        chk("r0_pend_out", 64'(pending), 64'd0);

        // Reset with three entries queued.
        pipe_alu(1'b1, 5'd22, 64'h3000);
        for (int k = 0; k < 3; k++) begin
            lr_valid = 1'b1; lr_dest = 5'(1 + k); lr_data = 64'h500 + 64'(k);
            step();
        end
        lr_valid = 1'b0;
        chk("pre_rst_pend", 64'(pending), 64'd3);
        chk("pre_rst_we", 64'(rf_we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pend", 64'(pending), 64'd0);
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_stall", 64'(stall), 64'd0);
        wb_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_we", 64'(rf_we), 64'd0);
        end
        chk("post_rst_pend", 64'(pending), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
